// File: rtl/image_frame_rx_if.sv
// Bit-stream input and label-result output channels of the image receiver.
// slave is the receiver side; master is the stream source / label consumer.
interface image_frame_rx_if #(
  parameter int LABEL_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               in_last;
  logic               lbl_valid;
  logic               lbl_ready;
  logic [LABEL_W-1:0] lbl_data;

  modport master (
    output in_valid, in_bit, in_last, lbl_ready,
    input  in_ready, lbl_valid, lbl_data
  );

  modport slave (
    input  in_valid, in_bit, in_last, lbl_ready,
    output in_ready, lbl_valid, lbl_data
  );
endinterface

// File: rtl/image_frame_rx.sv
// Serial image receiver: assembles one pixel bit per beat into an M1-bit
// vector, publishes it atomically to the combinational classifier, waits for
// the label to settle, then hands the label out on a valid/ready channel.
module image_frame_rx #(
  parameter int M1         = 324,
  parameter int LABEL_W    = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  image_frame_rx_if.slave    bus,
  output logic [M1-1:0]      img_out,
  input  logic [LABEL_W-1:0] label_in,
  output logic [CNT_W-1:0]   img_count,
  output logic               frame_err
);

  localparam int IDX_W = $clog2(M1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(M1 - 1);
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t             state_r, state_n;
  logic [IDX_W-1:0]   idx_r, idx_n;
  logic [M1-1:0]      shadow_r, shadow_n;
  logic [M1-1:0]      img_r, img_n;
  logic [3:0]         settle_r, settle_n;
  logic               lbl_valid_r, lbl_valid_n;
  logic [LABEL_W-1:0] lbl_data_r, lbl_data_n;
  logic [CNT_W-1:0]   count_r, count_n;
  logic               err_r, err_n;
  logic               in_ready_s;
  logic               beat_s;

  // Receiver is only open for bits while loading and out of reset.
  assign in_ready_s = (state_r == LOAD) && !rst;
  assign beat_s     = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.lbl_valid = lbl_valid_r;
  assign bus.lbl_data  = lbl_data_r;
  assign img_out       = img_r;
  assign img_count     = count_r;
  assign frame_err     = err_r;

  // Next-state and datapath: frame assembly, length checks, settle wait, label hand-off.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    shadow_n    = shadow_r;
    img_n       = img_r;
    settle_n    = settle_r;
    lbl_valid_n = lbl_valid_r;
    lbl_data_n  = lbl_data_r;
    count_n     = count_r;
    err_n       = err_r;
    case (state_r)
      LOAD: begin
        if (beat_s) begin
          shadow_n[idx_r] = bus.in_bit;
          if (idx_r == LAST_IDX) begin
            idx_n = {IDX_W{1'b0}};
            if (bus.in_last) begin
              // Whole vector published in one edge, final bit merged in.
              img_n    = shadow_n;
              settle_n = SETTLE_INIT;
              state_n  = SETTLE;
            end else begin
              // Frame ran past M1 bits: this bit is consumed, frame dropped.
              err_n = 1'b1;
            end
          end else if (bus.in_last) begin
            // Frame ended early: drop it, img_out keeps the previous image.
            err_n = 1'b1;
            idx_n = {IDX_W{1'b0}};
          end else begin
            idx_n = idx_r + IDX_W'(1);
          end
        end else begin
          state_n = LOAD;
        end
      end
      SETTLE: begin
        if (settle_r == 4'd0) begin
          lbl_data_n  = label_in;
          lbl_valid_n = 1'b1;
          state_n     = OUT;
        end else begin
          settle_n = settle_r - 4'd1;
        end
      end
      OUT: begin
        if (bus.lbl_ready) begin
          lbl_valid_n = 1'b0;
          count_n     = count_r + CNT_W'(1);
          state_n     = LOAD;
        end else begin
          state_n = OUT;
        end
      end
      default: begin
        state_n     = LOAD;
        idx_n       = {IDX_W{1'b0}};
        lbl_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD;
      idx_r       <= {IDX_W{1'b0}};
      shadow_r    <= {M1{1'b0}};
      img_r       <= {M1{1'b0}};
      settle_r    <= 4'd0;
      lbl_valid_r <= 1'b0;
      lbl_data_r  <= {LABEL_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      shadow_r    <= shadow_n;
      img_r       <= img_n;
      settle_r    <= settle_n;
      lbl_valid_r <= lbl_valid_n;
      lbl_data_r  <= lbl_data_n;
      count_r     <= count_n;
      err_r       <= err_n;
    end
  end

endmodule

// File: tb/tb_image_frame_rx.sv
// Scoreboard bench for image_frame_rx: dut_a uses default parameters,
// dut_b uses SETTLE_CYC=1 and a 2-bit counter to reach the wrap quickly.
module tb_image_frame_rx;
  localparam int M1 = 324;

  logic clk = 1'b0;
  logic rst;

  logic [M1-1:0] img_a, img_b;
  logic [3:0]    label_a, label_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;
  logic          err_a, err_b;

  int vectors = 0;
  int miscompares = 0;

  logic [M1-1:0] exp_img_q[$];
  logic [3:0]    exp_lbl_q[$];

  image_frame_rx_if #(.LABEL_W(4)) ifa ();
  image_frame_rx_if #(.LABEL_W(4)) ifb ();

  image_frame_rx #(.M1(M1), .LABEL_W(4), .SETTLE_CYC(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .img_out(img_a), .label_in(label_a),
    .img_count(cnt_a), .frame_err(err_a)
  );

  image_frame_rx #(.M1(M1), .LABEL_W(4), .SETTLE_CYC(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .img_out(img_b), .label_in(label_b),
    .img_count(cnt_b), .frame_err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ready(input bit w);
    return w ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic logic get_lvalid(input bit w);
    return w ? ifb.lbl_valid : ifa.lbl_valid;
  endfunction

  function automatic logic [3:0] get_ldata(input bit w);
    return w ? ifb.lbl_data : ifa.lbl_data;
  endfunction

  function automatic logic [M1-1:0] get_img(input bit w);
    return w ? img_b : img_a;
  endfunction

  function automatic logic [15:0] get_count(input bit w);
    return w ? {14'd0, cnt_b} : cnt_a;
  endfunction

  function automatic logic get_err(input bit w);
    return w ? err_b : err_a;
  endfunction

  function automatic logic [M1-1:0] rand_pat();
    logic [M1-1:0] p;
    for (int i = 0; i < M1; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic logic [M1-1:0] alt_pat();
    logic [M1-1:0] p;
    for (int i = 0; i < M1; i++) p[i] = 1'(i % 2);
    return p;
  endfunction

  task automatic set_in(input bit w, input logic v, input logic b, input logic l);
    if (w) begin
      ifb.in_valid = v; ifb.in_bit = b; ifb.in_last = l;
    end else begin
      ifa.in_valid = v; ifa.in_bit = b; ifa.in_last = l;
    end
  endtask

  task automatic set_lr(input bit w, input logic r);
    if (w) ifb.lbl_ready = r;
    else   ifa.lbl_ready = r;
  endtask

  // Streams beats first..stop-1 of pat; in_last on beat last_at (-1: never).
  task automatic send_frame(input bit w, input logic [M1-1:0] pat, input int first,
                            input int stop, input int last_at, input bit push);
    for (int k = first; k < stop; k++) begin
      int tmo = 0;
      set_in(w, 1'b1, pat[k], 1'(k == last_at));
      while (get_ready(w) !== 1'b1 && tmo < 50) begin
        step();
        tmo++;
      end
      if (tmo >= 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_frame in_ready timeout: beat %0d not accepted", k);
      end
      step();
    end
    set_in(w, 1'b0, 1'b0, 1'b0);
    if (push) begin
      exp_img_q.push_back(pat);
      exp_lbl_q.push_back(w ? label_b : label_a);
    end
  endtask

  // Waits for lbl_valid, checks settle latency and pops the scoreboard.
  task automatic wait_label(input bit w, input int exp_lat, input string tag);
    int lat = 0;
    logic [M1-1:0] ei;
    logic [3:0] el;
    while (get_lvalid(w) !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, want %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (exp_lbl_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: got label with empty queue, want a queued frame", tag);
    end else begin
      ei = exp_img_q.pop_front();
      el = exp_lbl_q.pop_front();
      if (get_ldata(w) !== el) begin
        miscompares++;
        $display("FAIL %s lbl_data: got %0d want %0d", tag, get_ldata(w), el);
      end
      vectors++;
      if (get_img(w) !== ei) begin
        miscompares++;
        $display("FAIL %s img_out: got %h want %h", tag, get_img(w), ei);
      end
    end
  endtask

  task automatic handshake(input bit w, input logic [15:0] exp_cnt, input string tag);
    vectors++;
    if (get_ready(w) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s in_ready before handshake: got %b want 0", tag, get_ready(w));
    end
    set_lr(w, 1'b1);
    step();
    set_lr(w, 1'b0);
    vectors++;
    if (get_lvalid(w) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s lbl_valid after handshake: got %b want 0", tag, get_lvalid(w));
    end
    vectors++;
    if (get_count(w) !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s img_count: got %0d want %0d", tag, get_count(w), exp_cnt);
    end
    vectors++;
    if (get_ready(w) !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready after handshake: got %b want 1", tag, get_ready(w));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_lr(1'b0, 1'b0);
    set_lr(1'b1, 1'b0);
    step();
    rst = 1'b0;
    #1;
    exp_img_q.delete();
    exp_lbl_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors++;
    if (ifa.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset in_ready during rst: got %b want 0", ifa.in_ready);
    end
    do_reset();
    vectors++;
    if (img_a !== {M1{1'b0}} || ifa.lbl_valid !== 1'b0 || ifa.lbl_data !== 4'd0 ||
        cnt_a !== 16'd0 || err_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset state: got img_zero=%b lv=%b ld=%0d cnt=%0d err=%b rdy=%b want 1 0 0 0 0 1",
               img_a == {M1{1'b0}}, ifa.lbl_valid, ifa.lbl_data, cnt_a, err_a, ifa.in_ready);
    end
  endtask

  task automatic test_basic();
    label_a = 4'd7;
    send_frame(1'b0, alt_pat(), 0, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "basic");
    handshake(1'b0, 16'd1, "basic");
  endtask

  task automatic test_hold();
    logic [M1-1:0] p = rand_pat();
    label_a = 4'd7;
    send_frame(1'b0, p, 0, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "hold");
    label_a = 4'd3;
    set_in(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (ifa.lbl_data !== 4'd7 || ifa.lbl_valid !== 1'b1 || ifa.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cycle %0d: got ld=%0d lv=%b rdy=%b want 7 1 0",
                 i, ifa.lbl_data, ifa.lbl_valid, ifa.in_ready);
      end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    handshake(1'b0, 16'd2, "hold");
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (cnt_a !== 16'd2 || img_a !== p) begin
      miscompares++;
      $display("FAIL hold after: got cnt=%0d img_same=%b want 2 1", cnt_a, img_a == p);
    end
  endtask

  task automatic test_short_frame();
    logic [M1-1:0] prev = img_a;
    logic [M1-1:0] p = rand_pat();
    label_a = 4'd5;
    send_frame(1'b0, rand_pat(), 0, 100, 99, 1'b0);
    vectors++;
    if (err_a !== 1'b1 || img_a !== prev || ifa.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL short frame: got err=%b img_same=%b rdy=%b want 1 1 1",
               err_a, img_a == prev, ifa.in_ready);
    end
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (ifa.lbl_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short frame lbl_valid: got %b want 0", ifa.lbl_valid);
    end
    label_a = 4'd9;
    send_frame(1'b0, p, 0, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "short_next");
    vectors++;
    if (err_a !== 1'b1) begin
      miscompares++;
      $display("FAIL short sticky frame_err: got %b want 1", err_a);
    end
    handshake(1'b0, 16'd3, "short_next");
  endtask

  task automatic test_long_frame();
    logic [M1-1:0] p = rand_pat();
    do_reset();
    vectors++;
    if (err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL long pre err: got %b want 0", err_a);
    end
    send_frame(1'b0, rand_pat(), 0, M1, -1, 1'b0);
    vectors++;
    if (err_a !== 1'b1 || img_a !== {M1{1'b0}} || ifa.lbl_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL long frame: got err=%b img_zero=%b lv=%b want 1 1 0",
               err_a, img_a == {M1{1'b0}}, ifa.lbl_valid);
    end
    label_a = 4'd12;
    send_frame(1'b0, p, 0, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "long_next");
    handshake(1'b0, 16'd1, "long_next");
  endtask

  task automatic test_reset_mid();
    logic [M1-1:0] ones = {M1{1'b1}};
    do_reset();
    send_frame(1'b0, ones, 0, 200, -1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (img_a !== {M1{1'b0}} || cnt_a !== 16'd0 || err_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got img_zero=%b cnt=%0d err=%b rdy=%b want 1 0 0 1",
               img_a == {M1{1'b0}}, cnt_a, err_a, ifa.in_ready);
    end
    label_a = 4'd1;
    send_frame(1'b0, ones, 0, M1 - 1, -1, 1'b0);
    vectors++;
    if (img_a !== {M1{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_mid partial img_out: got %h want 0", img_a);
    end
    send_frame(1'b0, ones, M1 - 1, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "reset_mid");
    vectors++;
    if (err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid frame_err: got %b want 0", err_a);
    end
    handshake(1'b0, 16'd1, "reset_mid");
    // Pending label dropped by reset.
    send_frame(1'b0, rand_pat(), 0, M1, M1 - 1, 1'b1);
    wait_label(1'b0, 2, "drop");
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (ifa.lbl_valid !== 1'b0 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL drop pending: got lv=%b cnt=%0d want 0 0", ifa.lbl_valid, cnt_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    label_b = 4'd7;
    send_frame(1'b1, alt_pat(), 0, M1, M1 - 1, 1'b1);
    wait_label(1'b1, 1, "settle1");
    handshake(1'b1, 16'd1, "settle1");
    for (int f = 2; f <= 4; f++) begin
      label_b = 4'(f + 8);
      send_frame(1'b1, rand_pat(), 0, M1, M1 - 1, 1'b1);
      wait_label(1'b1, 1, "wrap");
      handshake(1'b1, 16'(f % 4), "wrap");
    end
  endtask

  initial begin
    rst = 1'b1;
    label_a = 4'd0;
    label_b = 4'd0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_lr(1'b0, 1'b0);
    set_lr(1'b1, 1'b0);
    test_reset();
    test_basic();
    test_hold();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_frame_rx.md
Name: image_frame_rx

Overview:
- Hardware-side receiver for the image stream the inference bench transmits.
- Accepts a serial stream of one pixel bit per beat and assembles the 324-bit binarized image vector.
- Presents the vector atomically to the MM1/fullReLU/MM2/label chain, waits for the combinational result to settle, then returns the 4-bit predicted label on a valid/ready handshake.
- Replaces the bench-side file loop, so the network can be fed from a streaming source on-chip.

Parameters:
- M1, 324, pixels per image; width of the image vector.
- LABEL_W, 4, width of the class label.
- SETTLE_CYC, 2, cycles between image update and label capture; legal range 1..15.
- CNT_W, 16, width of the completed-image counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  receiver accepts a bit this cycle.
- in_bit  in  1  pixel bit.
- in_last  in  1  marks the final bit of a frame; qualified by in_valid.
- img_out  out  M1  assembled image; drives the MM1 B input.
- label_in  in  LABEL_W  label from the label module, combinational from img_out.
- lbl_valid  out  1  lbl_data holds a result.
- lbl_ready  in  1  downstream consumes the result.
- lbl_data  out  LABEL_W  captured label.
- img_count  out  CNT_W  number of labels consumed.
- frame_err  out  1  sticky flag: frame-length error seen.

Behaviour:
- Reset, synchronous, active-high; on the rising edge with rst=1, all of the following clear:
  - state goes to LOAD; bit index = 0; shadow register = 0.
  - img_out = 0; lbl_valid = 0; lbl_data = 0; img_count = 0; frame_err = 0.
- Reset mid-operation, in any state: the partial frame is discarded, and any pending label is dropped without incrementing img_count.
- in_ready is combinational: 1 only in LOAD and rst=0. A beat transfers when in_valid && in_ready.
- LOAD state:
  - Each beat writes in_bit to shadow[idx], then idx increments.
  - The first bit of a frame lands in index 0, the last bit in index M1-1.
- Frame completion: a beat with idx == M1-1 and in_last=1. On that edge:
  - img_out <= shadow, with the final bit merged in.
  - idx <= 0; settle counter <= SETTLE_CYC-1; state goes to SETTLE.
  - img_out changes only at this edge, so it is never partially updated.
- Length errors:
  - in_last=1 with idx < M1-1: set frame_err, discard the frame, idx <= 0, stay in LOAD. img_out is unchanged.
  - idx == M1-1 with in_last=0: set frame_err, discard the frame, idx <= 0, stay in LOAD. That bit is consumed.
  - frame_err clears only on rst.
- SETTLE state:
  - in_ready = 0.
  - The counter decrements each cycle.
  - When the counter is 0: lbl_data <= label_in, lbl_valid <= 1, state goes to OUT.
  - Latency: the label is captured SETTLE_CYC edges after the completing beat. With the default of 2, lbl_valid rises 2 cycles after the last beat.
- OUT state:
  - in_ready = 0.
  - lbl_valid and lbl_data hold until lbl_ready = 1.
  - On the handshake edge: lbl_valid <= 0, img_count <= img_count+1 (modulo 2^CNT_W, so 65535 wraps to 0), state goes to LOAD.
  - The next frame's first bit is accepted on the cycle after the handshake, never the same cycle.
- lbl_ready asserted outside OUT has no effect.
- in_valid outside LOAD is ignored; the source must hold the bit until in_ready.
- img_out is held between frames; the network result stays valid after lbl_valid drops.

Test Plan:
1. Reset, then stream 324 bits where bit i = i%2, with in_last on beat 324 and label_in tied to 4'd7 → img_out = alternating 0/1 pattern starting with index 0 = 0; lbl_valid rises 2 cycles after the last beat; lbl_data = 7; with lbl_ready=1, img_count = 1 and in_ready returns next cycle.
2. Hold lbl_ready=0 for 20 cycles in OUT while label_in changes 7→3 → lbl_data stays 7; in_ready stays 0; in_valid bits are ignored; after lbl_ready, img_count increments exactly once.
3. in_last on beat 100 → frame_err = 1; img_out unchanged from the prior frame; no lbl_valid. A following clean 324-bit frame completes normally, and frame_err stays 1.
4. 324 beats with no in_last → frame_err = 1; frame discarded; idx restarts, so a subsequent correct frame loads bits at indices 0..323.
5. Assert rst at beat 200 of a frame, then send a full frame of all ones → img_out = all ones only after completion (0 before); img_count = 0 → 1; frame_err = 0.
6. Preload img_count to 65535 via 65535 back-to-back frames (or a force), then complete one more frame → img_count wraps to 0. Repeat scenario 1 with SETTLE_CYC=1 → lbl_valid rises 1 cycle after the last beat.
